fir_output_quantizer: RTL



---
 rtl/fir_output_quantizer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fir_output_quantizer.sv
// rtl/fir_output_quantizer.sv - FIR output rescale, round-half-up, saturate, valid/ready
//
// Purpose:
//   Last stage of the FIR tap chain. Takes the A-bit signed accumulator sum,
//   drops SHIFT fractional bits with round-half-up (ties toward +inf),
//   saturates to an L-bit signed sample and presents it on a valid/ready
//   output. Two register stages, one sample per clock, full backpressure.
//   Saturation statistics (sticky flag and a saturating 16-bit counter) are
//   kept for the control processor.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset (highest priority)
//   in_valid   y_in holds a valid sum this cycle
//   in_ready   stage accepts y_in this cycle
//   y_in       A-bit signed accumulated sum
//   out_valid  out_data holds a valid sample
//   out_ready  consumer accepts out_data this cycle
//   out_data   L-bit signed rounded, saturated sample
//   sat_flag   sticky: at least one saturation since reset/clear
//   sat_count  saturated-sample count, holds at 65535
//   clr_stats  synchronous clear of sat_flag and sat_count

module fir_output_quantizer #(
  parameter int A     = 46,
  parameter int L     = 24,
  parameter int SHIFT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [A-1:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [L-1:0] out_data,
  output logic         sat_flag,
  output logic [15:0]  sat_count,
  input  logic         clr_stats
);

  // Width of the rounded value: A+1 bit sum with SHIFT bits dropped.
  // SHIFT <= A-L guarantees RW >= L+1, so the range test below is well formed.
  localparam int RW = A + 1 - SHIFT;

  localparam logic [A:0]   HALF  = {{A{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [L-1:0] MAX_S = {1'b0, {(L-1){1'b1}}};
  localparam logic [L-1:0] MIN_S = {1'b1, {(L-1){1'b0}}};

  logic [A:0]    w_sum;
  logic [RW-1:0] w_round;
  logic          w_unused;
  logic          w_s1_load;
  logic          w_s2_load;
  logic [RW-L:0] w_hi;
  logic          w_ovf;
  logic [L-1:0]  w_sat;
  logic          w_sat_event;

  logic          r_s1_valid;
  logic [RW-1:0] r_s1_data;
  logic          r_s2_valid;
  logic [L-1:0]  r_s2_data;
  logic          r_sat_flag;
  logic [15:0]   r_sat_count;

  // One extra bit of headroom makes the +half add overflow-free; taking the
  // upper bits of the sum is an arithmetic shift right, i.e. floor division.
  assign w_sum    = {y_in[A-1], y_in} + HALF;
  assign w_round  = w_sum[A:SHIFT];
  assign w_unused = &{1'b0, w_sum[SHIFT-1:0]};

  // S2 drains when empty or consumed; S1 follows when empty or S2 takes it.
  // in_ready depends only on state and out_ready, never on in_valid.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  // The value fits in L bits only when all bits from L-1 upward equal the sign.
  assign w_hi        = r_s1_data[RW-1:L-1];
  assign w_ovf       = !((&w_hi) || !(|w_hi));
  assign w_sat       = w_ovf ? (r_s1_data[RW-1] ? MIN_S : MAX_S) : r_s1_data[L-1:0];
  assign w_sat_event = w_s2_load && r_s1_valid && w_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= w_round;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_sat;
      end
    end
  end

  // Clear beats a coincident saturation event; that event is not counted.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      r_sat_flag  <= 1'b0;
      r_sat_count <= '0;
    end else if (w_sat_event) begin
      r_sat_flag <= 1'b1;
      if (r_sat_count != 16'hFFFF) begin
        r_sat_count <= r_sat_count + 16'd1;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign sat_flag  = r_sat_flag;
  assign sat_count = r_sat_count;

endmodule
